alu_mdu: RTL and testbench

ALU_MDU -- requirements
Module: alu_mdu

---
 rtl/alu_mdu_pkg.sv | 46 ++++
 rtl/alu_core.sv | 58 +++++
 rtl/alu_mdu.sv | 216 +++++++++++++++++++++
 tb/tb_alu_mdu.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mdu_pkg.sv
// alu_mdu_pkg: shared definitions for the ALU/MDU slice.
//   - ALU_TYPE_* / MDU_TYPE_* operation codes (compared at ARGS_WIDTH)
//   - state_t: sequencer states of alu_mdu
//   - ALL_ZERO / ALL_ONES: fill constants sliced down to DATA_WIDTH by users
package alu_mdu_pkg;

    localparam int unsigned ALU_TYPE_ADD  = 8'h01;
    localparam int unsigned ALU_TYPE_SUB  = 8'h02;
    localparam int unsigned ALU_TYPE_SLL  = 8'h03;
    localparam int unsigned ALU_TYPE_SRL  = 8'h04;
    localparam int unsigned ALU_TYPE_SRA  = 8'h05;
    localparam int unsigned ALU_TYPE_XOR  = 8'h06;
    localparam int unsigned ALU_TYPE_OR   = 8'h07;
    localparam int unsigned ALU_TYPE_AND  = 8'h08;
    localparam int unsigned ALU_TYPE_SLT  = 8'h09;
    localparam int unsigned ALU_TYPE_SLTU = 8'h0A;
    localparam int unsigned ALU_TYPE_BEQ  = 8'h0B;
    localparam int unsigned ALU_TYPE_BNE  = 8'h0C;
    localparam int unsigned ALU_TYPE_BLT  = 8'h0D;
    localparam int unsigned ALU_TYPE_BGE  = 8'h0E;
    localparam int unsigned ALU_TYPE_BLTU = 8'h0F;
    localparam int unsigned ALU_TYPE_BGEU = 8'h10;
    localparam int unsigned ALU_TYPE_JALR = 8'h11;

    localparam int unsigned MDU_TYPE_MUL    = 8'h20;
    localparam int unsigned MDU_TYPE_MULH   = 8'h21;
    localparam int unsigned MDU_TYPE_MULHSU = 8'h22;
    localparam int unsigned MDU_TYPE_MULHU  = 8'h23;
    localparam int unsigned MDU_TYPE_DIV    = 8'h24;
    localparam int unsigned MDU_TYPE_DIVU   = 8'h25;
    localparam int unsigned MDU_TYPE_REM    = 8'h26;
    localparam int unsigned MDU_TYPE_REMU   = 8'h27;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } state_t;

    // Widest legal DATA_WIDTH; modules slice [DATA_WIDTH-1:0] off these.
    localparam int unsigned MAX_WIDTH = 64;
    localparam logic [MAX_WIDTH-1:0] ALL_ZERO = '0;
    localparam logic [MAX_WIDTH-1:0] ALL_ONES = '1;

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational base-ALU (RV semantics).
//   i_type : operation code (ALU_TYPE_*); anything else yields zero
//   i_a    : operand 1 (rs1)
//   i_b    : operand 2 (rs2); low log2(DATA_WIDTH) bits are the shift amount
//   o_res  : result; compare ops return zero-extended 0/1
module alu_core
    import alu_mdu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ARGS_WIDTH = 8
) (
    input  logic [ARGS_WIDTH-1:0] i_type,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic [DATA_WIDTH-1:0] o_res
);

    localparam int unsigned SHW = $clog2(DATA_WIDTH);

    logic [SHW-1:0]        w_shamt;
    logic [DATA_WIDTH-1:0] w_sum;
    logic [DATA_WIDTH-1:0] w_diff;
    logic                  w_lt;
    logic                  w_ltu;
    logic                  w_eq;

    assign w_shamt = i_b[SHW-1:0];
    assign w_sum   = i_a + i_b;
    assign w_diff  = i_a - i_b;
    assign w_lt    = $signed(i_a) < $signed(i_b);
    assign w_ltu   = i_a < i_b;
    assign w_eq    = i_a == i_b;

    always_comb begin
        o_res = ALL_ZERO[DATA_WIDTH-1:0];
        case (i_type)
            ARGS_WIDTH'(ALU_TYPE_ADD):  o_res = w_sum;
            ARGS_WIDTH'(ALU_TYPE_SUB):  o_res = w_diff;
            ARGS_WIDTH'(ALU_TYPE_SLL):  o_res = i_a << w_shamt;
            ARGS_WIDTH'(ALU_TYPE_SRL):  o_res = i_a >> w_shamt;
            ARGS_WIDTH'(ALU_TYPE_SRA):  o_res = $unsigned($signed(i_a) >>> w_shamt);
            ARGS_WIDTH'(ALU_TYPE_XOR):  o_res = i_a ^ i_b;
            ARGS_WIDTH'(ALU_TYPE_OR):   o_res = i_a | i_b;
            ARGS_WIDTH'(ALU_TYPE_AND):  o_res = i_a & i_b;
            ARGS_WIDTH'(ALU_TYPE_SLT):  o_res = {{(DATA_WIDTH-1){1'b0}}, w_lt};
            ARGS_WIDTH'(ALU_TYPE_SLTU): o_res = {{(DATA_WIDTH-1){1'b0}}, w_ltu};
            ARGS_WIDTH'(ALU_TYPE_BEQ):  o_res = {{(DATA_WIDTH-1){1'b0}}, w_eq};
            ARGS_WIDTH'(ALU_TYPE_BNE):  o_res = {{(DATA_WIDTH-1){1'b0}}, !w_eq};
            ARGS_WIDTH'(ALU_TYPE_BLT):  o_res = {{(DATA_WIDTH-1){1'b0}}, w_lt};
            ARGS_WIDTH'(ALU_TYPE_BGE):  o_res = {{(DATA_WIDTH-1){1'b0}}, !w_lt};
            ARGS_WIDTH'(ALU_TYPE_BLTU): o_res = {{(DATA_WIDTH-1){1'b0}}, w_ltu};
            ARGS_WIDTH'(ALU_TYPE_BGEU): o_res = {{(DATA_WIDTH-1){1'b0}}, !w_ltu};
            ARGS_WIDTH'(ALU_TYPE_JALR): o_res = {w_sum[DATA_WIDTH-1:1], 1'b0};
            default:                    o_res = ALL_ZERO[DATA_WIDTH-1:0];
        endcase
    end

endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: ALU plus iterative multiply/divide unit with valid/ready handshakes.
//   i_clk, i_rst (async, active-high), i_flush (sync abort)
//   i_valid/o_ready : request handshake (o_ready only in IDLE)
//   i_type, i_rs1_data, i_rs2_data : operation code and operands
//   o_valid/i_ready : result handshake; o_res holds while stalled
// Base ALU ops and divide special cases finish in 1 cycle; MUL*/DIV*/REM*
// take DATA_WIDTH+1 cycles through a shared radix-2 datapath.
module alu_mdu
    import alu_mdu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ARGS_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [ARGS_WIDTH-1:0] i_type,
    input  logic [DATA_WIDTH-1:0] i_rs1_data,
    input  logic [DATA_WIDTH-1:0] i_rs2_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_res
);

    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(DATA_WIDTH - 1);
    localparam logic [W-1:0]  ZERO      = ALL_ZERO[W-1:0];
    localparam logic [W-1:0]  ONES      = ALL_ONES[W-1:0];
    localparam logic [W-1:0]  MOST_NEG  = {1'b1, ZERO[W-2:0]};

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    // r_hi/r_lo: product {hi,lo} for MUL, remainder/quotient for DIV.
    // r_opb: multiplicand magnitude (MUL) or divisor magnitude (DIV).
    logic [W-1:0]  r_hi;
    logic [W-1:0]  r_lo;
    logic [W-1:0]  r_opb;
    logic [W-1:0]  r_res;
    logic          r_neg;   // negate the final magnitude
    logic          r_high;  // MUL: take high half; DIV: take remainder

    logic [W-1:0]  w_alu_res;
    logic          w_is_mul;
    logic          w_is_div;
    logic          w_sgn1;
    logic          w_sgn2;
    logic          w_rem;
    logic          w_high;
    logic          w_neg1;
    logic          w_neg2;
    logic [W-1:0]  w_mag1;
    logic [W-1:0]  w_mag2;
    logic          w_div_zero;
    logic          w_div_ovf;
    logic          w_div_special;
    logic [W-1:0]  w_special_res;

    logic [W:0]    w_mul_sum;
    logic [W-1:0]  w_mul_hi;
    logic [W-1:0]  w_mul_lo;
    logic [2*W-1:0] w_prod;
    logic [2*W-1:0] w_prod_s;
    logic [W-1:0]  w_mul_res;
    logic [W:0]    w_div_shift;
    logic          w_div_ge;
    logic [W-1:0]  w_div_diff;
    logic [W-1:0]  w_div_hi;
    logic [W-1:0]  w_div_lo;
    logic [W-1:0]  w_div_pick;
    logic [W-1:0]  w_div_res;

    alu_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .ARGS_WIDTH (ARGS_WIDTH)
    ) u_alu_core (
        .i_type (i_type),
        .i_a    (i_rs1_data),
        .i_b    (i_rs2_data),
        .o_res  (w_alu_res)
    );

    always_comb begin
        w_is_mul = 1'b0;
        w_is_div = 1'b0;
        w_sgn1   = 1'b0;
        w_sgn2   = 1'b0;
        w_rem    = 1'b0;
        w_high   = 1'b0;
        case (i_type)
            ARGS_WIDTH'(MDU_TYPE_MUL):    begin w_is_mul = 1'b1; w_sgn1 = 1'b1; w_sgn2 = 1'b1; end
            ARGS_WIDTH'(MDU_TYPE_MULH):   begin w_is_mul = 1'b1; w_sgn1 = 1'b1; w_sgn2 = 1'b1; w_high = 1'b1; end
            ARGS_WIDTH'(MDU_TYPE_MULHSU): begin w_is_mul = 1'b1; w_sgn1 = 1'b1; w_high = 1'b1; end
            ARGS_WIDTH'(MDU_TYPE_MULHU):  begin w_is_mul = 1'b1; w_high = 1'b1; end
            ARGS_WIDTH'(MDU_TYPE_DIV):    begin w_is_div = 1'b1; w_sgn1 = 1'b1; w_sgn2 = 1'b1; end
            ARGS_WIDTH'(MDU_TYPE_DIVU):   begin w_is_div = 1'b1; end
            ARGS_WIDTH'(MDU_TYPE_REM):    begin w_is_div = 1'b1; w_sgn1 = 1'b1; w_sgn2 = 1'b1; w_rem = 1'b1; end
            ARGS_WIDTH'(MDU_TYPE_REMU):   begin w_is_div = 1'b1; w_rem = 1'b1; end
            default: ;
        endcase
    end

    assign w_neg1        = w_sgn1 & i_rs1_data[W-1];
    assign w_neg2        = w_sgn2 & i_rs2_data[W-1];
    assign w_mag1        = w_neg1 ? (ZERO - i_rs1_data) : i_rs1_data;
    assign w_mag2        = w_neg2 ? (ZERO - i_rs2_data) : i_rs2_data;
    assign w_div_zero    = (i_rs2_data == ZERO);
    assign w_div_ovf     = w_sgn1 & (i_rs1_data == MOST_NEG) & (i_rs2_data == ONES);
    assign w_div_special = w_div_zero | w_div_ovf;
    assign w_special_res = w_div_zero ? (w_rem ? i_rs1_data : ONES)
                                      : (w_rem ? ZERO : i_rs1_data);

    // Shift-add step: conditionally add multiplicand to the high half, then
    // shift the whole {hi,lo} right; after W steps {hi,lo} is the product.
    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : {1'b0, ZERO});
    assign w_mul_hi  = w_mul_sum[W:1];
    assign w_mul_lo  = {w_mul_sum[0], r_lo[W-1:1]};
    assign w_prod    = {w_mul_hi, w_mul_lo};
    assign w_prod_s  = r_neg ? ({ZERO, ZERO} - w_prod) : w_prod;
    assign w_mul_res = r_high ? w_prod_s[2*W-1:W] : w_prod_s[W-1:0];

    // Restoring step: the partial remainder stays below the divisor, so the
    // shifted value fits in W+1 bits and the difference fits in W bits.
    assign w_div_shift = {r_hi, r_lo[W-1]};
    assign w_div_ge    = w_div_shift >= {1'b0, r_opb};
    assign w_div_diff  = w_div_shift[W-1:0] - r_opb;
    assign w_div_hi    = w_div_ge ? w_div_diff : w_div_shift[W-1:0];
    assign w_div_lo    = {r_lo[W-2:0], w_div_ge};
    assign w_div_pick  = r_high ? w_div_hi : w_div_lo;
    assign w_div_res   = r_neg ? (ZERO - w_div_pick) : w_div_pick;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_valid) begin
                    if (w_is_mul)                        w_next = ST_MUL;
                    else if (w_is_div && !w_div_special) w_next = ST_DIV;
                    else                                 w_next = ST_DONE;
                end
            end
            ST_MUL, ST_DIV: if (r_cnt == LAST_STEP) w_next = ST_DONE;
            ST_DONE:        if (i_ready) w_next = ST_IDLE;
            default:        w_next = ST_IDLE;
        endcase
        if (i_flush) w_next = ST_IDLE;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_opb  <= '0;
            r_res  <= '0;
            r_neg  <= 1'b0;
            r_high <= 1'b0;
        end else if (i_flush) begin
            r_cnt <= '0;
            r_res <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_valid) begin
                        r_cnt <= '0;
                        if (w_is_mul) begin
                            r_hi   <= ZERO;
                            r_lo   <= w_mag2;
                            r_opb  <= w_mag1;
                            r_neg  <= w_neg1 ^ w_neg2;
                            r_high <= w_high;
                        end else if (w_is_div) begin
                            if (w_div_special) begin
                                r_res <= w_special_res;
                            end else begin
                                r_hi   <= ZERO;
                                r_lo   <= w_mag1;
                                r_opb  <= w_mag2;
                                r_neg  <= w_rem ? w_neg1 : (w_neg1 ^ w_neg2);
                                r_high <= w_rem;
                            end
                        end else begin
                            r_res <= w_alu_res;
                        end
                    end
                end
                ST_MUL: begin
                    r_hi  <= w_mul_hi;
                    r_lo  <= w_mul_lo;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST_STEP) r_res <= w_mul_res;
                end
                ST_DIV: begin
                    r_hi  <= w_div_hi;
                    r_lo  <= w_div_lo;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST_STEP) r_res <= w_div_res;
                end
                default: ;
            endcase
        end
    end

    assign o_ready = (r_state == ST_IDLE);
    assign o_valid = (r_state == ST_DONE);
    assign o_res   = r_res;

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: drives a 32-bit and a 64-bit alu_mdu in lockstep and compares
// each against an arithmetic reference model (result and latency).
module tb_alu_mdu;
    import alu_mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        valid;
    logic        rdy;
    logic [7:0]  typ;
    logic [63:0] rs1;
    logic [63:0] rs2;

    logic        ready32, valid32, ready64, valid64;
    logic [31:0] res32;
    logic [63:0] res64;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [31:0] last_res32;

    always #5 clk = ~clk;

    alu_mdu #(.DATA_WIDTH(32), .ARGS_WIDTH(8)) dut32 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid), .o_ready(ready32),
        .i_type(typ), .i_rs1_data(rs1[31:0]), .i_rs2_data(rs2[31:0]),
        .o_valid(valid32), .i_ready(rdy), .o_res(res32)
    );

    alu_mdu #(.DATA_WIDTH(64), .ARGS_WIDTH(8)) dut64 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid), .o_ready(ready64),
        .i_type(typ), .i_rs1_data(rs1), .i_rs2_data(rs2),
        .o_valid(valid64), .i_ready(rdy), .o_res(res64)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic longint sext(input int w, input logic [63:0] x);
        if (w == 32) return longint'({{32{x[31]}}, x[31:0]});
        return longint'(x);
    endfunction

    function automatic logic is_ovf(input int w, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] mn;
        mn = 64'd1 << (w - 1);
        return (sext(w, a) == sext(w, mn)) && (sext(w, b) == -64'sd1);
    endfunction

    function automatic logic [63:0] ref_op(input int w, input logic [7:0] tp,
                                           input logic [63:0] ai, input logic [63:0] bi);
        logic [63:0]         m, a, b, r;
        longint              sa, sb;
        int                  sh;
        logic signed [127:0] p;
        m  = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        a  = ai & m;
        b  = bi & m;
        sa = sext(w, a);
        sb = sext(w, b);
        sh = int'(b % 64'(w));
        p  = '0;
        r  = '0;
        case (int'(tp))
            ALU_TYPE_ADD:  r = a + b;
            ALU_TYPE_SUB:  r = a - b;
            ALU_TYPE_SLL:  r = a << sh;
            ALU_TYPE_SRL:  r = a >> sh;
            ALU_TYPE_SRA:  r = 64'(sa >>> sh);
            ALU_TYPE_XOR:  r = a ^ b;
            ALU_TYPE_OR:   r = a | b;
            ALU_TYPE_AND:  r = a & b;
            ALU_TYPE_SLT:  r = 64'(sa < sb);
            ALU_TYPE_SLTU: r = 64'(a < b);
            ALU_TYPE_BEQ:  r = 64'(a == b);
            ALU_TYPE_BNE:  r = 64'(a != b);
            ALU_TYPE_BLT:  r = 64'(sa < sb);
            ALU_TYPE_BGE:  r = 64'(sa >= sb);
            ALU_TYPE_BLTU: r = 64'(a < b);
            ALU_TYPE_BGEU: r = 64'(a >= b);
            ALU_TYPE_JALR: r = (a + b) & ~64'd1;
            MDU_TYPE_MUL: begin
                p = $signed({{64{sa[63]}}, sa}) * $signed({{64{sb[63]}}, sb});
                r = p[63:0];
            end
            MDU_TYPE_MULH: begin
                p = $signed({{64{sa[63]}}, sa}) * $signed({{64{sb[63]}}, sb});
                r = 64'(p >> w);
            end
            MDU_TYPE_MULHSU: begin
                p = $signed({{64{sa[63]}}, sa}) * $signed({64'd0, b});
                r = 64'(p >> w);
            end
            MDU_TYPE_MULHU: begin
                p = {64'd0, a} * {64'd0, b};
                r = 64'(p >> w);
            end
            MDU_TYPE_DIV:  r = (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : is_ovf(w, a, b) ? a : 64'(sa / sb);
            MDU_TYPE_DIVU: r = (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
            MDU_TYPE_REM:  r = (b == 0) ? a : is_ovf(w, a, b) ? 64'd0 : 64'(sa % sb);
            MDU_TYPE_REMU: r = (b == 0) ? a : a % b;
            default:       r = '0;
        endcase
        return r & m;
    endfunction

    function automatic int unsigned ref_lat(input int w, input logic [7:0] tp,
                                            input logic [63:0] ai, input logic [63:0] bi);
        logic [63:0] m;
        m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        case (int'(tp))
            MDU_TYPE_MUL, MDU_TYPE_MULH, MDU_TYPE_MULHSU, MDU_TYPE_MULHU:
                return w + 1;
            MDU_TYPE_DIV, MDU_TYPE_REM:
                return ((bi & m) == 0 || is_ovf(w, ai & m, bi & m)) ? 1 : w + 1;
            MDU_TYPE_DIVU, MDU_TYPE_REMU:
                return ((bi & m) == 0) ? 1 : w + 1;
            default:
                return 1;
        endcase
    endfunction

    task automatic run_op(input logic [7:0] tp, input logic [63:0] a, input logic [63:0] b);
        int unsigned lat32, lat64;
        logic [63:0] got32, got64;
        lat32 = 0; lat64 = 0; got32 = '0; got64 = '0;
        @(negedge clk);
        check_eq("ready_before", {62'd0, ready32, ready64}, 64'd3);
        valid = 1'b1; typ = tp; rs1 = a; rs2 = b;
        @(negedge clk);
        valid = 1'b0;
        rs1 = {$urandom, $urandom};
        rs2 = {$urandom, $urandom};
        typ = 8'($urandom);
        for (int c = 1; c <= 80; c++) begin
            if (lat32 == 0 && valid32) begin lat32 = c; got32 = 64'(res32); end
            if (lat64 == 0 && valid64) begin lat64 = c; got64 = res64; end
            if (lat32 != 0 && lat64 != 0) break;
            @(negedge clk);
        end
        check_eq($sformatf("lat32 op=%h", tp), 64'(lat32), 64'(ref_lat(32, tp, a, b)));
        check_eq($sformatf("res32 op=%h a=%h b=%h", tp, a[31:0], b[31:0]), got32, ref_op(32, tp, a, b));
        check_eq($sformatf("lat64 op=%h", tp), 64'(lat64), 64'(ref_lat(64, tp, a, b)));
        check_eq($sformatf("res64 op=%h a=%h b=%h", tp, a, b), got64, ref_op(64, tp, a, b));
        @(negedge clk);
        check_eq("idle_after", {60'd0, valid32, ready32, valid64, ready64}, 64'b0101);
        last_res32 = got32[31:0];
    endtask

    function automatic logic [63:0] pick();
        case ($urandom % 8)
            0:       return 64'd0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h0000_0000_8000_0000;
            4:       return 64'hFFFF_FFFF_8000_0000;
            5:       return 64'($urandom % 16);
            default: return {$urandom, $urandom};
        endcase
    endfunction

    int unsigned op_list[26] = '{
        ALU_TYPE_ADD, ALU_TYPE_SUB, ALU_TYPE_SLL, ALU_TYPE_SRL, ALU_TYPE_SRA,
        ALU_TYPE_XOR, ALU_TYPE_OR, ALU_TYPE_AND, ALU_TYPE_SLT, ALU_TYPE_SLTU,
        ALU_TYPE_BEQ, ALU_TYPE_BNE, ALU_TYPE_BLT, ALU_TYPE_BGE, ALU_TYPE_BLTU,
        ALU_TYPE_BGEU, ALU_TYPE_JALR, MDU_TYPE_MUL, MDU_TYPE_MULH, MDU_TYPE_MULHSU,
        MDU_TYPE_MULHU, MDU_TYPE_DIV, MDU_TYPE_DIVU, MDU_TYPE_REM, MDU_TYPE_REMU, 8'hFF
    };

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] held;
        rst = 1'b1; flush = 1'b0; valid = 1'b0; rdy = 1'b1;
        typ = '0; rs1 = '0; rs2 = '0; last_res32 = '0;
        #12;
        check_eq("reset_state32", {31'd0, valid32, ready32, res32}, {31'd0, 1'b0, 1'b1, 32'd0});
        check_eq("reset_state64", {62'd0, valid64, ready64}, 64'd1);
        check_eq("reset_res64", res64, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        run_op(8'(ALU_TYPE_ADD), 64'd5, 64'd7);
        check_eq("add_5_7", 64'(last_res32), 64'd12);
        run_op(8'(MDU_TYPE_MULH), 64'h8000_0000, 64'h8000_0000);
        check_eq("mulh_min_min", 64'(last_res32), 64'h4000_0000);
        run_op(8'(MDU_TYPE_MULHU), 64'hFFFF_FFFF, 64'hFFFF_FFFF);
        check_eq("mulhu_ones", 64'(last_res32), 64'hFFFF_FFFE);
        run_op(8'(MDU_TYPE_DIV), -64'sd7, 64'd2);
        check_eq("div_m7_2", 64'(last_res32), 64'hFFFF_FFFD);
        run_op(8'(MDU_TYPE_REM), -64'sd7, 64'd2);
        check_eq("rem_m7_2", 64'(last_res32), 64'hFFFF_FFFF);
        run_op(8'(MDU_TYPE_DIVU), 64'd7, 64'd0);
        check_eq("divu_by_zero", 64'(last_res32), 64'hFFFF_FFFF);
        run_op(8'(MDU_TYPE_REM), 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("rem_overflow", 64'(last_res32), 64'd0);
        run_op(8'(MDU_TYPE_DIV), 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op(8'(ALU_TYPE_SRA), 64'h8000_0000_0000_0000, 64'd63);
        run_op(8'(ALU_TYPE_JALR), 64'd1001, 64'd2);
        run_op(8'h00, 64'd3, 64'd4);

        // Result held while the consumer stalls
        rdy = 1'b0;
        @(negedge clk);
        valid = 1'b1; typ = 8'(ALU_TYPE_SUB); rs1 = 64'd100; rs2 = 64'd58;
        @(negedge clk);
        valid = 1'b0; rs1 = {$urandom, $urandom}; rs2 = {$urandom, $urandom};
        held = res32;
        check_eq("hold_first", {62'd0, valid32, valid64}, 64'd3);
        check_eq("hold_res", 64'(held), 64'd42);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq($sformatf("hold_cycle%0d", i),
                     {28'd0, valid32, ready32, valid64, ready64, res32},
                     {28'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd42});
        end
        rdy = 1'b1;
        @(negedge clk);
        check_eq("hold_release", {60'd0, valid32, ready32, valid64, ready64}, 64'b0101);

        // Flush during a divide
        @(negedge clk);
        valid = 1'b1; typ = 8'(MDU_TYPE_DIV); rs1 = 64'd100; rs2 = 64'd7;
        @(negedge clk);
        valid = 1'b0;
        repeat (8) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_eq("flush_idle", {60'd0, valid32, ready32, valid64, ready64}, 64'b0101);
        run_op(8'(ALU_TYPE_ADD), 64'd123456, 64'd654321);
        check_eq("add_after_flush", 64'(last_res32), 64'd777777);

        // Asynchronous reset in the middle of a multiply
        run_op(8'(ALU_TYPE_ADD), 64'd5, 64'd7);
        @(negedge clk);
        valid = 1'b1; typ = 8'(MDU_TYPE_MUL); rs1 = 64'd1234; rs2 = 64'd5678;
        @(negedge clk);
        valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst32", {31'd0, valid32, ready32, res32}, {31'd0, 1'b0, 1'b1, 32'd0});
        check_eq("async_rst64", {63'd0, valid64}, 64'd0);
        check_eq("async_rst64_res", res64, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(8'(MDU_TYPE_MUL), 64'd1234, 64'd5678);

        // Random traffic against the reference model
        for (int n = 0; n < 120; n++) begin
            run_op(8'(op_list[$urandom % 26]), pick(), pick());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
